serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor, the subtraction counterpart to the team's ripple full-adder datapath. Computes diff = A - B - Bin over W cycles, one bit per cycle, LSB first, using a single full-subtractor cell and a registered borrow. Operands arrive and results leave on valid/ready handshakes. Used where area matters more than latency.

Parameters:
W, 8, operand/result width in bits; legal range W >= 1.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b, bin are valid
in_ready  output  1  block can accept operands
a  input  W  minuend
b  input  W  subtrahend
bin  input  1  borrow-in
out_valid  output  1  diff, bout, ovf are valid
out_ready  input  1  consumer accepts the result
diff  output  W  (a - b - bin) mod 2^W
bout  output  1  unsigned borrow-out; 1 iff a < b + bin (unsigned)
ovf  output  1  signed overflow of the subtraction

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, out_valid=0, diff=0, bout=0, ovf=0, borrow register=0, bit counter=0.
- While rst=1: in_ready=0. After reset, in_ready = (state==IDLE).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture a and b into shift registers, bin into the borrow flop, and a[W-1] and b[W-1] into sign flops. Clear the counter. Go to RUN.
- RUN:
  - in_ready=0.
  - Each edge, process bit x=a_sr[0], y=b_sr[0], r=borrow:
    - d = x^y^r
    - borrow_next = (~x&y) | (~(x^y)&r)
  - Shift d into the diff shift register from the MSB end, and shift a_sr and b_sr right.
  - Counter increments. On the edge that processes bit W-1, go to DONE with:
    - diff = full result
    - bout = final borrow
    - ovf = (sa != sb) & (diff[W-1] != sa)
- Latency: out_valid goes high exactly W rising edges after the accepting edge.
- DONE:
  - out_valid=1.
  - diff, bout and ovf are held stable while out_ready=0.
  - On out_ready=1, go to IDLE. out_valid=0 and in_ready=1 from the next cycle.
  - Minimum issue interval is W+2 cycles.
- Inputs a, b, bin and in_valid are ignored outside IDLE. Values changing during RUN have no effect.
- Outputs diff, bout and ovf are registered. Their value outside DONE is don't-care but must not glitch in DONE.
- Reset mid-RUN or in DONE aborts the operation. No out_valid is produced, and the pending result is discarded.
- W=1: a single RUN cycle. The counter is at least 1 bit wide.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- W=8, a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, ovf=0; out_valid rises exactly 8 edges after acceptance.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0. a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
- Signed overflow:
  - a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b -> diff/bout/ovf stable, in_ready=0, nothing accepted. Raise out_ready -> in_ready=1 the next cycle, and the next operation computes correctly.
- Reset asserted while processing bit 3 -> out_valid never asserts; in_ready=1 the cycle after rst drops. The following a=0x10, b=0x01 gives diff=0x0F, bout=0.
- Back-to-back random operations with W=1, 8 and 13 -> every result matches (a-b-bin) mod 2^W, plus the unsigned borrow and signed overflow rules.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor. It computes diff = a - b - bin one
//   bit per cycle, LSB first. A single full-subtractor cell works against a
//   registered borrow.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous, active-high reset
//     in_valid   operands a, b, bin are valid
//     in_ready   block can accept operands (IDLE and not in reset)
//     a, b       minuend / subtrahend, W bits
//     bin        borrow-in
//     out_valid  diff, bout, ovf are valid (DONE)
//     out_ready  consumer accepts the result
//     diff       (a - b - bin) mod 2^W
//     bout       unsigned borrow-out
//     ovf        signed overflow, from the operand signs and the result sign
//
//   state  | meaning
//   -------+--------------------------------------------------
//   IDLE   | waiting for operands, in_ready=1
//   RUN    | processing one bit per edge, W edges in total
//   DONE   | result held stable until out_ready
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  // The counter is at least one bit wide, so W=1 still elaborates.
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_a_sr;
  logic [W-1:0]   r_b_sr;
  logic [W-1:0]   r_diff;
  logic           r_borrow;
  logic           r_sa;
  logic           r_sb;
  logic           r_bout;
  logic           r_ovf;
  logic [CW-1:0]  r_cnt;

  logic           w_x;
  logic           w_y;
  logic           w_d;
  logic           w_borrow_next;
  logic           w_last;
  logic           w_accept;
  logic [W-1:0]   w_diff_next;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;

  // Full-subtractor cell on the current LSBs.
  assign w_x           = r_a_sr[0];
  assign w_y           = r_b_sr[0];
  assign w_d           = w_x ^ w_y ^ r_borrow;
  assign w_borrow_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
  assign w_last        = (r_cnt == CW'(W - 1));

  // The new bit enters at the MSB. After W shifts, bit 0 has reached
  // position 0. Written this way rather than as a slice so that W=1 is legal.
  always_comb begin
    w_diff_next        = r_diff >> 1;
    w_diff_next[W-1]   = w_d;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= bin;
            r_sa     <= a[W-1];
            r_sb     <= b[W-1];
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_diff   <= w_diff_next;
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_borrow <= w_borrow_next;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_bout <= w_borrow_next;
            // On this edge w_d lands in diff[W-1], so it is the result sign.
            r_ovf  <= (r_sa != r_sb) && (w_d != r_sa);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        bin;
  logic        out_ready;
  logic [12:0] a13;
  logic [12:0] b13;

  logic        in_ready1, out_valid1, bout1, ovf1;
  logic [0:0]  diff1;
  logic        in_ready8, out_valid8, bout8, ovf8;
  logic [7:0]  diff8;
  logic        in_ready13, out_valid13, bout13, ovf13;
  logic [12:0] diff13;

  int checks;
  int failures;

  // captured results of the most recent operation
  logic        cd1, cb1, co1;
  logic [7:0]  cd8;
  logic        cb8, co8;
  logic [12:0] cd13;
  logic        cb13, co13;
  int          l1, l8, l13;
  bit          tmo;

  serial_subtractor #(.W(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a13[0:0]), .b(b13[0:0]), .bin(bin), .out_valid(out_valid1),
    .out_ready(out_ready), .diff(diff1), .bout(bout1), .ovf(ovf1)
  );

  serial_subtractor #(.W(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a13[7:0]), .b(b13[7:0]), .bin(bin), .out_valid(out_valid8),
    .out_ready(out_ready), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.W(13)) u_w13 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready13),
    .a(a13), .b(b13), .bin(bin), .out_valid(out_valid13),
    .out_ready(out_ready), .diff(diff13), .bout(bout13), .ovf(ovf13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, bout, diff} for a w-bit subtraction.
  function automatic logic [14:0] model(input int w, input logic [12:0] ta,
                                        input logic [12:0] tb_, input logic tbin);
    longint m, aa, bb, d;
    logic bo, ov, sa, sb, sd;
    m  = (longint'(1) << w) - 1;
    aa = longint'(ta) & m;
    bb = longint'(tb_) & m;
    d  = (aa - bb - longint'(tbin)) & m;
    bo = (aa < (bb + longint'(tbin)));
    sa = ((aa >> (w - 1)) & 1) != 0;
    sb = ((bb >> (w - 1)) & 1) != 0;
    sd = ((d  >> (w - 1)) & 1) != 0;
    ov = (sa != sb) && (sd != sa);
    return {ov, bo, d[12:0]};
  endfunction

  // Present operands to all three instances, then wait until each raises
  // out_valid and record its result and its latency in edges.
  task automatic start_op(input logic [12:0] ta, input logic [12:0] tb_,
                          input logic tbin);
    bit g1, g8, g13;
    @(negedge clk);
    a13 = ta; b13 = tb_; bin = tbin; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    g1 = 0; g8 = 0; g13 = 0; tmo = 0;
    l1 = -1; l8 = -1; l13 = -1;
    for (int c = 1; c <= 40 && !(g1 && g8 && g13); c++) begin
      @(posedge clk);
      #1;
      if (out_valid1 && !g1) begin
        g1 = 1; l1 = c; cd1 = diff1[0]; cb1 = bout1; co1 = ovf1;
      end
      if (out_valid8 && !g8) begin
        g8 = 1; l8 = c; cd8 = diff8; cb8 = bout8; co8 = ovf8;
      end
      if (out_valid13 && !g13) begin
        g13 = 1; l13 = c; cd13 = diff13; cb13 = bout13; co13 = ovf13;
      end
    end
    if (!(g1 && g8 && g13)) tmo = 1;
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready8 !== 1'b0 || in_ready1 !== 1'b0 || in_ready13 !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready_during_rst got=%b%b%b exp=000", in_ready1, in_ready8, in_ready13);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready8 !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready8);
    end
    checks++;
    if (out_valid8 !== 1'b0 || out_valid1 !== 1'b0 || out_valid13 !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b%b%b exp=000", out_valid1, out_valid8, out_valid13);
    end
    checks++;
    if ({diff8, bout8, ovf8} !== 10'h000 || diff13 !== 13'h0) begin
      failures++; $display("FAIL reset_outputs got=%h/%b/%b/%h exp=0", diff8, bout8, ovf8, diff13);
    end
  endtask

  task automatic test_basic();
    logic [7:0] va[5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
    logic [7:0] vb[5] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF};
    logic       vi[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] ed[5] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80};
    logic       eb[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       eo[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      start_op({5'd0, va[i]}, {5'd0, vb[i]}, vi[i]);
      checks++;
      if (tmo) begin
        failures++; $display("FAIL basic_timeout vec=%0d got=no_out_valid exp=out_valid", i);
      end
      checks++;
      if (cd8 !== ed[i]) begin
        failures++; $display("FAIL basic_diff vec=%0d got=%h exp=%h", i, cd8, ed[i]);
      end
      checks++;
      if (cb8 !== eb[i]) begin
        failures++; $display("FAIL basic_bout vec=%0d got=%b exp=%b", i, cb8, eb[i]);
      end
      checks++;
      if (co8 !== eo[i]) begin
        failures++; $display("FAIL basic_ovf vec=%0d got=%b exp=%b", i, co8, eo[i]);
      end
      checks++;
      if (l8 != 8) begin
        failures++; $display("FAIL basic_latency vec=%0d got=%0d exp=8", i, l8);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    start_op(13'h005, 13'h003, 1'b0);
    checks++;
    if (tmo || cd8 !== 8'h02) begin
      failures++; $display("FAIL bp_first_diff got=%h exp=02", cd8);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a13 = 13'($urandom);
      b13 = 13'($urandom);
      bin = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({diff8, bout8, ovf8} !== {8'h02, 1'b0, 1'b0} || out_valid8 !== 1'b1 || in_ready8 !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got=%h/%b/%b v=%b r=%b exp=02/0/0 v=1 r=0",
                 i, diff8, bout8, ovf8, out_valid8, in_ready8);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      failures++; $display("FAIL bp_release got=r%b v%b exp=r1 v0", in_ready8, out_valid8);
    end
    start_op(13'h022, 13'h011, 1'b1);
    checks++;
    if (tmo || cd8 !== 8'h10 || cb8 !== 1'b0 || co8 !== 1'b0) begin
      failures++; $display("FAIL bp_next_op got=%h/%b/%b exp=10/0/0", cd8, cb8, co8);
    end
    finish_op();
  endtask

  task automatic test_abort();
    bit seen;
    @(negedge clk);
    a13 = 13'h055; b13 = 13'h022; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready8 !== 1'b1) begin
      failures++; $display("FAIL abort_in_ready got=%b exp=1", in_ready8);
    end
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (out_valid8 || out_valid13) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++; $display("FAIL abort_no_out_valid got=1 exp=0");
    end
    start_op(13'h010, 13'h001, 1'b0);
    checks++;
    if (tmo || cd8 !== 8'h0F || cb8 !== 1'b0) begin
      failures++; $display("FAIL abort_next_op got=%h/%b exp=0f/0", cd8, cb8);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [12:0] ta, tb_;
    logic        tbin;
    logic [14:0] e1, e8, e13;
    for (int n = 0; n < 25; n++) begin
      ta   = 13'($urandom);
      tb_  = 13'($urandom);
      tbin = 1'($urandom);
      e1   = model(1, ta, tb_, tbin);
      e8   = model(8, ta, tb_, tbin);
      e13  = model(13, ta, tb_, tbin);
      start_op(ta, tb_, tbin);
      checks++;
      if (tmo || l1 != 1 || l8 != 8 || l13 != 13) begin
        failures++; $display("FAIL b2b_latency n=%0d got=%0d/%0d/%0d exp=1/8/13", n, l1, l8, l13);
      end
      checks++;
      if ({co1, cb1, cd1} !== {e1[14], e1[13], e1[0]}) begin
        failures++; $display("FAIL b2b_w1 n=%0d got=%b%b%b exp=%b%b%b", n, co1, cb1, cd1, e1[14], e1[13], e1[0]);
      end
      checks++;
      if ({co8, cb8, cd8} !== {e8[14], e8[13], e8[7:0]}) begin
        failures++; $display("FAIL b2b_w8 n=%0d got=%b/%b/%h exp=%b/%b/%h", n, co8, cb8, cd8, e8[14], e8[13], e8[7:0]);
      end
      checks++;
      if ({co13, cb13, cd13} !== e13) begin
        failures++; $display("FAIL b2b_w13 n=%0d got=%b/%b/%h exp=%b/%b/%h", n, co13, cb13, cd13, e13[14], e13[13], e13[12:0]);
      end
      finish_op();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bin = 1'b0;
    a13 = '0; b13 = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
